// File: rtl/alu_seq_flags.sv
// alu_seq_flags: registered ALU with start/busy/done handshake, persistent
// C/Z/N/V flag register, selectable ADC carry source and iterative shifts
// (one bit per clock).
module alu_seq_flags #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SHR_ARITH = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             Carryin,
  input  logic             use_cflag,
  output logic [WIDTH-1:0] alu_out,
  output logic             Carryout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SW  = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SW-1:0]    cnt;
  logic             shr_dir;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] res_c;
  logic             c_c;
  logic             v_c;
  logic             cin_c;
  logic [SW-1:0]    amt_c;
  logic             is_shift_c;
  logic [WIDTH-1:0] step_c;
  logic             out_bit_c;
  logic             fill_c;

  // Single-cycle result and flags from the live operands; shifts by 0 pass Ain through.
  always_comb begin
    cin_c = use_cflag ? Carryout : Carryin;
    sum_c = '0;
    res_c = Ain;
    c_c   = Carryout;
    v_c   = 1'b0;
    case (op_sel)
      OP_ADD: begin
        sum_c = {1'b0, Ain} + {1'b0, Bin};
        res_c = sum_c[MSB:0];
        c_c   = sum_c[WIDTH];
        v_c   = (Ain[MSB] == Bin[MSB]) && (res_c[MSB] != Ain[MSB]);
      end
      OP_ADC: begin
        sum_c = {1'b0, Ain} + {1'b0, Bin} + {{WIDTH{1'b0}}, cin_c};
        res_c = sum_c[MSB:0];
        c_c   = sum_c[WIDTH];
        v_c   = (Ain[MSB] == Bin[MSB]) && (res_c[MSB] != Ain[MSB]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the no-borrow flag.
        sum_c = {1'b0, Ain} + {1'b0, ~Bin} + {{WIDTH{1'b0}}, 1'b1};
        res_c = sum_c[MSB:0];
        c_c   = sum_c[WIDTH];
        v_c   = (Ain[MSB] != Bin[MSB]) && (res_c[MSB] != Ain[MSB]);
      end
      OP_AND: res_c = Ain & Bin;
      OP_OR:  res_c = Ain | Bin;
      OP_XOR: res_c = Ain ^ Bin;
      default: res_c = Ain;
    endcase
  end

  // Shift decode from the live request.
  always_comb begin
    amt_c      = Bin[SW-1:0];
    is_shift_c = (op_sel[2:1] == 2'b11);
  end

  // One-bit shift step of the working register and the bit that falls out.
  always_comb begin
    fill_c = SHR_ARITH ? work[MSB] : 1'b0;
    if (shr_dir) begin
      step_c    = {fill_c, work[MSB:1]};
      out_bit_c = work[0];
    end else begin
      step_c    = {work[MSB-1:0], 1'b0};
      out_bit_c = work[MSB];
    end
  end

  // Control FSM, result and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      alu_out  <= '0;
      Carryout <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      work     <= '0;
      cnt      <= '0;
      shr_dir  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_shift_c && (amt_c != '0)) begin
              work    <= Ain;
              cnt     <= amt_c;
              shr_dir <= op_sel[0];
              busy    <= 1'b1;
              state   <= SHIFT;
            end else begin
              alu_out  <= res_c;
              Carryout <= c_c;
              zero     <= (res_c == '0);
              neg      <= res_c[MSB];
              ovf      <= v_c;
              done     <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= step_c;
          cnt  <= cnt - SW'(1);
          // Final step: publish result, last shifted-out bit becomes C.
          if (cnt == SW'(1)) begin
            alu_out  <= step_c;
            Carryout <= out_bit_c;
            zero     <= (step_c == '0);
            neg      <= step_c[MSB];
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_flags.sv
// Bench for alu_seq_flags: directed vector table, hand-written reset/handshake
// sequences, then random operations against an arithmetic reference model.
// Two instances (logical and arithmetic SHR) share all inputs.
module tb_alu_seq_flags;

  localparam int W    = 8;
  localparam int MASK = 255;

  logic       clk = 1'b0;
  logic       reset, start, carryin, use_cflag;
  logic [2:0] op_sel;
  logic [7:0] ain, bin;
  logic [7:0] out0, out1;
  logic       c0, z0, n0, v0, busy0, done0;
  logic       c1, z1, n1, v1, busy1, done1;

  always #5 clk = ~clk;

  alu_seq_flags #(.WIDTH(W), .SHR_ARITH(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start), .op_sel(op_sel), .Ain(ain), .Bin(bin),
    .Carryin(carryin), .use_cflag(use_cflag), .alu_out(out0), .Carryout(c0),
    .zero(z0), .neg(n0), .ovf(v0), .busy(busy0), .done(done0));

  alu_seq_flags #(.WIDTH(W), .SHR_ARITH(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start), .op_sel(op_sel), .Ain(ain), .Bin(bin),
    .Carryin(carryin), .use_cflag(use_cflag), .alu_out(out1), .Carryout(c1),
    .zero(z1), .neg(n1), .ovf(v1), .busy(busy1), .done(done1));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per instance (index = SHR_ARITH).
  int m_out[2], m_c[2], m_z[2], m_n[2], m_v[2];

  typedef struct {
    int op, a, b, cin, usec;
    bit inj;
    int out, c, z, n, v, out_ar;
  } vec_t;

  vec_t tbl[18];

  task automatic report(input string name, input bit bad, input int got, input int exp);
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input int exp);
    report(name, got !== 1'(exp), int'(got), exp);
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input int exp);
    report(name, got !== 8'(exp), int'(got), exp);
  endtask

  task automatic chki(input string name, input int got, input int exp);
    report(name, got != exp, got, exp);
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic bit in_range(input int s);
    return (s >= -128) && (s <= 127);
  endfunction

  // Expected result from plain integer arithmetic.
  function automatic void model(input int ar, input int op, input int a, input int b,
                                input int cin_ext, input int usec,
                                output int r, output int c, output int v, output int lat);
    int cin, s, k;
    r   = a;
    c   = m_c[ar];
    v   = 0;
    lat = 1;
    cin = (usec != 0) ? m_c[ar] : cin_ext;
    case (op)
      0, 1: begin
        if (op == 0) cin = 0;
        s = a + b + cin;
        r = s & MASK;
        c = (s > MASK) ? 1 : 0;
        v = in_range(sgn(a) + sgn(b) + cin) ? 0 : 1;
      end
      2: begin
        r = (a - b) & MASK;
        c = (a >= b) ? 1 : 0;
        v = in_range(sgn(a) - sgn(b)) ? 0 : 1;
      end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      default: begin
        k = b % W;
        if (k > 0) begin
          lat = k + 1;
          if (op == 6) begin
            r = (a << k) & MASK;
            c = (a >> (W - k)) & 1;
          end else begin
            c = (a >> (k - 1)) & 1;
            r = (ar != 0) ? ((sgn(a) >>> k) & MASK) : (a >> k);
          end
        end
      end
    endcase
  endfunction

  // Issue one operation in the current cycle and follow it to its done pulse.
  task automatic run_op(input int op, input int a, input int b, input int cin_ext,
                        input int usec, input bit inject);
    int r[2], c[2], v[2], lat[2];
    int cyc;
    for (int ar = 0; ar < 2; ar++) model(ar, op, a, b, cin_ext, usec, r[ar], c[ar], v[ar], lat[ar]);
    op_sel    = 3'(op);
    ain       = 8'(a);
    bin       = 8'(b);
    carryin   = 1'(cin_ext);
    use_cflag = 1'(usec);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (!done0 && cyc < 40) begin
      chk1("busy_during_shift", busy0, 1);
      chk8("hold_out0", out0, m_out[0]);
      chk8("hold_out1", out1, m_out[1]);
      if (inject && cyc == 1 && lat[0] >= 3) begin
        start  = 1'b1;
        op_sel = 3'd0;
        ain    = 8'($urandom);
        bin    = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chki("latency", cyc, lat[0]);
    chk1("done1_pulse", done1, 1);
    chk1("busy_at_done", busy0, 0);
    for (int ar = 0; ar < 2; ar++) begin
      m_out[ar] = r[ar];
      m_c[ar]   = c[ar];
      m_v[ar]   = v[ar];
      m_z[ar]   = (r[ar] == 0) ? 1 : 0;
      m_n[ar]   = (r[ar] >> 7) & 1;
    end
    chk8("out0", out0, m_out[0]);
    chk1("c0", c0, m_c[0]);
    chk1("z0", z0, m_z[0]);
    chk1("n0", n0, m_n[0]);
    chk1("v0", v0, m_v[0]);
    chk8("out1", out1, m_out[1]);
    chk1("c1", c1, m_c[1]);
    chk1("z1", z1, m_z[1]);
    chk1("n1", n1, m_n[1]);
    chk1("v1", v1, m_v[1]);
  endtask

  task automatic model_clear();
    for (int ar = 0; ar < 2; ar++) begin
      m_out[ar] = 0; m_c[ar] = 0; m_z[ar] = 0; m_n[ar] = 0; m_v[ar] = 0;
    end
  endtask

  initial begin
    //         op  a      b      cin usec inj  out    c  z  n  v  out_ar
    tbl[0]  = '{0, 'hCC, 'h55, 0, 0, 1'b0, 'h21, 1, 0, 0, 0, 'h21};
    tbl[1]  = '{3, 'hCC, 'h55, 0, 0, 1'b0, 'h44, 1, 0, 0, 0, 'h44};
    tbl[2]  = '{4, 'hCC, 'h55, 0, 0, 1'b0, 'hDD, 1, 0, 1, 0, 'hDD};
    tbl[3]  = '{5, 'hCC, 'h55, 0, 0, 1'b0, 'h99, 1, 0, 1, 0, 'h99};
    tbl[4]  = '{2, 10,   6,    0, 0, 1'b0, 'h04, 1, 0, 0, 0, 'h04};
    tbl[5]  = '{2, 6,    10,   0, 0, 1'b0, 'hFC, 0, 0, 1, 0, 'hFC};
    tbl[6]  = '{2, 'h33, 'h33, 0, 0, 1'b0, 'h00, 1, 1, 0, 0, 'h00};
    tbl[7]  = '{0, 'hFF, 'h01, 0, 0, 1'b0, 'h00, 1, 1, 0, 0, 'h00};
    tbl[8]  = '{1, 'h7F, 'h00, 0, 1, 1'b0, 'h80, 0, 0, 1, 1, 'h80};
    tbl[9]  = '{1, 'h7F, 'h00, 0, 0, 1'b0, 'h7F, 0, 0, 0, 0, 'h7F};
    tbl[10] = '{1, 'h01, 'h01, 1, 0, 1'b0, 'h03, 0, 0, 0, 0, 'h03};
    tbl[11] = '{6, 'hCC, 'h03, 0, 0, 1'b1, 'h60, 0, 0, 0, 0, 'h60};
    tbl[12] = '{7, 'hCC, 'h02, 0, 0, 1'b0, 'h33, 0, 0, 0, 0, 'hF3};
    tbl[13] = '{2, 'h33, 'h33, 0, 0, 1'b0, 'h00, 1, 1, 0, 0, 'h00};
    tbl[14] = '{7, 'hCC, 'h08, 0, 0, 1'b0, 'hCC, 1, 0, 1, 0, 'hCC};
    tbl[15] = '{6, 'h81, 'h00, 0, 0, 1'b0, 'h81, 1, 0, 1, 0, 'h81};
    tbl[16] = '{6, 'h81, 'h01, 0, 0, 1'b0, 'h02, 1, 0, 0, 0, 'h02};
    tbl[17] = '{7, 'h81, 'h07, 0, 0, 1'b1, 'h01, 0, 0, 0, 0, 'hFF};

    reset = 1'b1; start = 1'b0; op_sel = 3'd0; ain = 8'd0; bin = 8'd0;
    carryin = 1'b0; use_cflag = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk8("rst_out0", out0, 0);
    chk1("rst_c0", c0, 0);
    chk1("rst_z0", z0, 0);
    chk1("rst_n0", n0, 0);
    chk1("rst_v0", v0, 0);
    chk1("rst_busy0", busy0, 0);
    chk1("rst_done0", done0, 0);
    chk8("rst_out1", out1, 0);

    // Reset wins over a simultaneous start.
    start = 1'b1; op_sel = 3'd0; ain = 8'h12; bin = 8'h34;
    @(posedge clk); #1;
    chk1("rst_vs_start_done", done0, 0);
    chk8("rst_vs_start_out", out0, 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Directed table; each op is issued in the done cycle of the previous one.
    for (int i = 0; i < 18; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].usec, tbl[i].inj);
      chk8($sformatf("tbl%0d_out", i), out0, tbl[i].out);
      chk1($sformatf("tbl%0d_c", i), c0, tbl[i].c);
      chk1($sformatf("tbl%0d_z", i), z0, tbl[i].z);
      chk1($sformatf("tbl%0d_n", i), n0, tbl[i].n);
      chk1($sformatf("tbl%0d_v", i), v0, tbl[i].v);
      chk8($sformatf("tbl%0d_out_arith", i), out1, tbl[i].out_ar);
    end

    // done is a single-cycle pulse once no new op follows.
    @(posedge clk); #1;
    chk1("done_falls", done0, 0);
    chk8("idle_hold_out", out0, m_out[0]);

    // Reset during the second cycle of SHL by 3 aborts with no result.
    op_sel = 3'd6; ain = 8'hCC; bin = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("abort_busy_before", busy0, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    chk1("abort_busy", busy0, 0);
    chk8("abort_out", out0, 0);
    chk1("abort_c", c0, 0);
    chk1("abort_done", done0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk1("abort_no_done", done0, 0);
      chk1("abort_no_busy", busy0, 0);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_flags.md
Name: alu_seq_flags

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Adds a start/busy/done handshake, a persistent flag register (C/Z/N/V), selectable carry source for add-with-carry, and iterative multi-cycle shifts (one bit per clock).
- Sits between the register file and the writeback path of the parametrised CPU datapath.

Parameters:
- WIDTH, 8, datapath width in bits; must be >= 2.
- SHR_ARITH, 0, 0 = SHR fills with 0; 1 = SHR replicates the MSB.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only while not busy.
- op_sel  input  3  operation code, latched on an accepted start.
- Ain  input  WIDTH  operand A, latched on an accepted start.
- Bin  input  WIDTH  operand B; for shifts, Bin[SW-1:0] is the shift amount, SW = clog2(WIDTH).
- Carryin  input  1  external carry for ADC when use_cflag=0.
- use_cflag  input  1  1 = ADC uses the stored Carryout flag instead of Carryin.
- alu_out  output  WIDTH  registered result.
- Carryout  output  1  C flag, registered.
- zero  output  1  Z flag, registered.
- neg  output  1  N flag, registered.
- ovf  output  1  V flag, registered.
- busy  output  1  high while a multi-cycle shift is in progress.
- done  output  1  one-cycle pulse when alu_out and the flags update.

Behaviour:
- One clock and a synchronous active-high reset; reset is sampled on the clk rising edge.
- Reset values: alu_out=0, Carryout=0, zero=0, neg=0, ovf=0, busy=0, done=0, FSM in IDLE. Reset wins over start in the same cycle.
- FSM states are IDLE and SHIFT.
- op_sel encoding:
  - 0 ADD: A+B
  - 1 ADC: A+B+cin, where cin = use_cflag ? Carryout : Carryin
  - 2 SUB: A+~B+1
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL
  - 7 SHR
- Accepted start = start && !busy, in IDLE. A start while busy is ignored completely; no operand or opcode is latched.
- Ops 0-5, and ops 6/7 with shift amount 0: the result is written on the clock edge that samples start, and done=1 in the following cycle. Latency is 1 and busy stays 0.
- Shifts with amount k>0:
  - On the accept edge: latch work=Ain and cnt=k, then go to SHIFT with busy=1.
  - On each SHIFT edge: shift work by 1, capture the shifted-out bit, and decrement cnt.
  - On the edge where cnt reaches 0: write alu_out and the flags, clear busy, return to IDLE.
  - done=1 in the cycle k+1 after the start cycle; total latency is k+1 cycles.
- alu_out and all flags hold their values while busy and update only on completion.
- Flag rules for the result R:
  - Z = (R==0); N = R[WIDTH-1].
  - ADD/ADC: C = carry out of the MSB; V = signed overflow.
  - SUB: C = no-borrow, so C=1 iff Ain>=Bin unsigned; V = signed overflow.
  - AND/OR/XOR: C unchanged; V=0.
  - Shifts: C = last bit shifted out; V=0. Shift by 0 leaves C unchanged and gives R=Ain.
- Arithmetic is modulo 2^WIDTH; the carry is computed in WIDTH+1 bits.
- done falls the next cycle unless a new single-cycle op completes. Back-to-back single-cycle starts give done high every cycle.
- A start in the same cycle as done (IDLE) is accepted.
- Reset mid-shift aborts the shift: busy=0, done=0, outputs cleared, and no partial result is written.
- Shift amounts >= WIDTH are possible when WIDTH is not a power of two. They run the full count, so SHL gives 0.

Test Plan (WIDTH=8):
- Ain=0xCC, Bin=0x55, op 0/3/4/5 -> alu_out 0x21 (C=1, V=0), 0x44, 0xDD (N=1), 0x99; done one cycle after each start; busy stays 0.
- SUB: Ain=10, Bin=6 -> 0x04, C=1, Z=0. Then Ain=6, Bin=10 -> 0xFC, C=0, N=1. Then Ain=Bin=0x33 -> 0x00, Z=1, C=1.
- ADD 0xFF+0x01 (gives C=1, Z=1), then ADC use_cflag=1 with Ain=0x7F, Bin=0x00 -> 0x80, V=1, N=1, C=0. Repeat with use_cflag=0, Carryin=0 -> 0x7F, V=0.
- SHL Ain=0xCC, Bin=3 -> busy high for 3 cycles, done on cycle 4, alu_out=0x60, C=0; alu_out holds its previous value while busy.
- SHR Ain=0xCC, Bin=2 -> 0x33 with SHR_ARITH=0, 0xF3 with SHR_ARITH=1, C=0. Shift by 0 -> 0xCC, C unchanged, done after 1 cycle.
- Start pulsed mid-shift is ignored (result still 0x60). Reset asserted at cycle 2 of SHL by 3 -> busy=0, alu_out=0, no done pulse. Start on the done cycle is accepted.
